// File: rtl/ranging_pkg.sv
// Shared types and constants for the ultrasonic ranging scheduler.
package ranging_pkg;

    localparam int unsigned CNT_W = 20;
    localparam int unsigned OUT_W = 32;
    localparam int unsigned SUM_W = 22;

    // Default timing for the 12 MHz on-chip oscillator
    localparam int unsigned DEF_TRIG_CYCLES         = 120;
    localparam int unsigned DEF_PERIOD_CYCLES       = 720000;
    localparam int unsigned DEF_RISE_TIMEOUT_CYCLES = 60000;
    localparam int unsigned DEF_ECHO_TIMEOUT_CYCLES = 456000;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        HOLDOFF
    } state_t;

endpackage

// File: rtl/echo_sync.sv
// Two-flop synchronizer for the raw echo pin with edge detection against the previous synced value.
module echo_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic sync,
    output logic rise_c,
    output logic fall_c
);

    logic meta;
    logic prev;

    // Synchronizer chain plus one-cycle history for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= d;
            sync <= meta;
            prev <= sync;
        end
    end

    assign rise_c = sync & ~prev;
    assign fall_c = ~sync & prev;

endmodule

// File: rtl/ranging_scheduler.sv
// Ultrasonic ranger sequencer: periodic trigger, echo width timing with timeouts, valid/timeout strobes.
// Optional macro RANGING_AVG4_EN: echo_cycles reports the mean of the last four valid widths.
module ranging_scheduler
    import ranging_pkg::*;
#(
    parameter int unsigned TRIG_CYCLES         = DEF_TRIG_CYCLES,
    parameter int unsigned PERIOD_CYCLES       = DEF_PERIOD_CYCLES,
    parameter int unsigned RISE_TIMEOUT_CYCLES = DEF_RISE_TIMEOUT_CYCLES,
    parameter int unsigned ECHO_TIMEOUT_CYCLES = DEF_ECHO_TIMEOUT_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             echo,
    output logic             trig,
    output logic             busy,
    output logic [OUT_W-1:0] echo_cycles,
    output logic             valid,
    output logic             timeout,
    output logic             led
);

    localparam logic [CNT_W-1:0] TRIG_LAST   = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PERIOD_CYCLES - 1);
    localparam logic [CNT_W-1:0] RISE_LAST   = CNT_W'(RISE_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] ECHO_MAX    = CNT_W'(ECHO_TIMEOUT_CYCLES);

    state_t           state, state_d;
    logic             echo_s, echo_rise_c, echo_fall_c;
    logic [CNT_W-1:0] phase_cnt, phase_d;
    logic [CNT_W-1:0] width_cnt, width_d;
    logic [CNT_W-1:0] period_cnt, period_d;
    logic             trig_d, busy_d, valid_d, timeout_d;
    logic             capture_c;
    logic [OUT_W-1:0] new_echo_c;

    echo_sync u_echo_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .d      (echo),
        .sync   (echo_s),
        .rise_c (echo_rise_c),
        .fall_c (echo_fall_c)
    );

    assign led = echo_s;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    // Next-state logic; a trigger is never launched while echo is high
    always_comb begin
        state_d = state;
        case (state)
            IDLE:      if (enable && !echo_s) state_d = TRIG;
            TRIG:      if (phase_cnt == TRIG_LAST) state_d = WAIT_RISE;
            WAIT_RISE: begin
                if (echo_rise_c)                  state_d = MEASURE;
                else if (phase_cnt == RISE_LAST)  state_d = HOLDOFF;
            end
            MEASURE: begin
                if (echo_fall_c)                  state_d = HOLDOFF;
                else if (width_cnt == ECHO_MAX)   state_d = HOLDOFF;
            end
            HOLDOFF: begin
                if (period_cnt == PERIOD_LAST && !echo_s)
                    state_d = enable ? TRIG : IDLE;
            end
            default:   state_d = IDLE;
        endcase
    end

    // Counter and output next values
    always_comb begin
        phase_d   = phase_cnt;
        width_d   = width_cnt;
        period_d  = (period_cnt == PERIOD_LAST) ? period_cnt : period_cnt + CNT_W'(1);
        valid_d   = 1'b0;
        timeout_d = 1'b0;
        capture_c = 1'b0;
        case (state)
            IDLE, HOLDOFF: phase_d = '0;
            TRIG:          phase_d = (state_d == TRIG) ? phase_cnt + CNT_W'(1) : '0;
            WAIT_RISE: begin
                if (echo_rise_c)                 width_d   = CNT_W'(1);
                else if (phase_cnt == RISE_LAST) timeout_d = 1'b1;
                else                             phase_d   = phase_cnt + CNT_W'(1);
            end
            MEASURE: begin
                if (echo_fall_c) begin
                    capture_c = 1'b1;
                    valid_d   = 1'b1;
                end else if (width_cnt == ECHO_MAX) begin
                    timeout_d = 1'b1;
                end else begin
                    width_d = width_cnt + CNT_W'(1);
                end
            end
            default: phase_d = '0;
        endcase
        if (state != TRIG && state_d == TRIG) period_d = '0;
        trig_d = (state_d == TRIG);
        busy_d = (state_d != IDLE);
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_cnt   <= '0;
            width_cnt   <= '0;
            period_cnt  <= '0;
            trig        <= 1'b0;
            busy        <= 1'b0;
            valid       <= 1'b0;
            timeout     <= 1'b0;
            echo_cycles <= '0;
        end else begin
            phase_cnt  <= phase_d;
            width_cnt  <= width_d;
            period_cnt <= period_d;
            trig       <= trig_d;
            busy       <= busy_d;
            valid      <= valid_d;
            timeout    <= timeout_d;
            if (capture_c) echo_cycles <= new_echo_c;
        end
    end

`ifdef RANGING_AVG4_EN
    logic [3:0][CNT_W-1:0] win;
    logic [1:0]            wr_ptr;
    logic                  primed;
    logic [SUM_W-1:0]      sum_q, sum_nx;

    // Running sum after folding in the current width; the first sample fills the whole window
    always_comb begin
        if (primed) sum_nx = sum_q - SUM_W'(win[wr_ptr]) + SUM_W'(width_cnt);
        else        sum_nx = SUM_W'(width_cnt) << 2;
    end

    // Window storage, replaced oldest-first on each valid width
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win    <= '0;
            wr_ptr <= '0;
            primed <= 1'b0;
            sum_q  <= '0;
        end else if (capture_c) begin
            sum_q  <= sum_nx;
            primed <= 1'b1;
            wr_ptr <= wr_ptr + 2'd1;
            if (primed) win[wr_ptr] <= width_cnt;
            else        win         <= {4{width_cnt}};
        end
    end

    assign new_echo_c = OUT_W'(sum_nx >> 2);
`else
    assign new_echo_c = OUT_W'(width_cnt);
`endif

endmodule

// File: tb/tb_ranging_scheduler.sv
// Directed + randomized bench for ranging_scheduler with scaled-down timing parameters.
module tb_ranging_scheduler;

    localparam int TRIG = 8;
    localparam int PER  = 400;
    localparam int RTO  = 60;
    localparam int ETO  = 150;

    logic        clk, rst_n, enable, echo;
    logic        trig, busy, valid, timeout, led;
    logic [31:0] echo_cycles;

    ranging_scheduler #(
        .TRIG_CYCLES         (TRIG),
        .PERIOD_CYCLES       (PER),
        .RISE_TIMEOUT_CYCLES (RTO),
        .ECHO_TIMEOUT_CYCLES (ETO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .echo        (echo),
        .trig        (trig),
        .busy        (busy),
        .echo_cycles (echo_cycles),
        .valid       (valid),
        .timeout     (timeout),
        .led         (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total = 0, bad = 0, cyc = 0;
    int          rise_cnt = 0, hi_len = 0, last_len = 0;
    int          vcnt = 0, tcnt = 0, vcyc = 0, tcyc = 0, both = 0, dbl = 0;
    logic [31:0] vval = '0;
    logic        trig_prev = 1'b0, vprev = 1'b0, tprev = 1'b0;
    bit          rose, fell;
    int          hist[$];
    logic [31:0] exp_echo = '0;
    int          cur_r;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock, sampled 1 time unit after the rising edge, logging strobe events
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        rose = trig && !trig_prev;
        fell = !trig && trig_prev;
        if (rose) rise_cnt++;
        if (trig) hi_len++;
        if (fell) begin
            last_len = hi_len;
            hi_len   = 0;
        end
        if (valid) begin
            vcnt++;
            vcyc = cyc;
            vval = echo_cycles;
        end
        if (timeout) begin
            tcnt++;
            tcyc = cyc;
        end
        if (valid && timeout) both++;
        if ((valid && vprev) || (timeout && tprev)) dbl++;
        vprev     = valid;
        tprev     = timeout;
        trig_prev = trig;
    endtask

    // Reference for the published width after a valid measurement of w cycles
    task automatic model_valid(input int w);
`ifdef RANGING_AVG4_EN
        int s;
        if (hist.size() == 0) repeat (4) hist.push_back(w);
        else begin
            void'(hist.pop_front());
            hist.push_back(w);
        end
        s = 0;
        foreach (hist[i]) s += hist[i];
        exp_echo = 32'(s / 4);
`else
        exp_echo = 32'(w);
`endif
    endtask

    task automatic wait_rise(output int rc, input int limit);
        int n = 0;
        rose = 0;
        while (!rose && n < limit) begin
            step();
            n++;
        end
        check("trig_rose", 64'(rose), 1);
        rc = cyc;
    endtask

    task automatic wait_fall(output int f);
        int n = 0;
        fell = 0;
        while (!fell && n < TRIG + 5) begin
            step();
            n++;
        end
        check("trig_fell", 64'(fell), 1);
        check("trig_len", 64'(last_len), TRIG);
        f = cyc;
    endtask

    // One ranging cycle: echo pin high for w cycles starting d cycles after trig fall (w=0: no echo)
    task automatic meas(input int r, input int f, input int d, input int w,
                        input bit exp_rise, input int drop_at, output int rn);
        int kind, ecyc, nr, limit, v0, t0, r0;
        if (w == 0 || d + 3 > RTO) begin
            kind = 2; ecyc = f + RTO;
        end else if (w <= ETO) begin
            kind = 1; ecyc = f + d + w + 3;
        end else begin
            kind = 2; ecyc = f + d + 3 + ETO;
        end
        nr = r + PER;
        if (w > 0 && f + d + w + 3 > nr) nr = f + d + w + 3;
        limit = nr + 20;
        v0 = vcnt; t0 = tcnt; r0 = rise_cnt;
        while (cyc < limit && !(exp_rise && rise_cnt != r0)) begin
            if (w > 0 && cyc == f + d)     echo = 1'b1;
            if (w > 0 && cyc == f + d + w) echo = 1'b0;
            if (cyc == drop_at)            enable = 1'b0;
            step();
        end
        echo = 1'b0;
        check("strobe_count", 64'((vcnt - v0) + (tcnt - t0)), 1);
        if (kind == 1) begin
            model_valid(w);
            check("valid_cyc", 64'(vcyc), 64'(ecyc));
            check("valid_val", 64'(vval), 64'(exp_echo));
        end else begin
            check("timeout_cyc", 64'(tcyc), 64'(ecyc));
            check("echo_kept", 64'(echo_cycles), 64'(exp_echo));
        end
        if (exp_rise) check("next_rise", 64'(cyc), 64'(nr));
        else          check("no_rise", 64'(rise_cnt - r0), 0);
        rn = cyc;
    endtask

    task automatic run(input int d, input int w);
        int f;
        wait_fall(f);
        meas(cur_r, f, d, w, 1'b1, -1, cur_r);
    endtask

    initial begin
        int c, f, r0, d, w, sel;
        rst_n  = 1'b0;
        enable = 1'b1;
        echo   = 1'b0;
        repeat (3) step();
        check("rst_trig", 64'(trig), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_echo_cycles", 64'(echo_cycles), 0);
        check("rst_valid", 64'(valid), 0);
        check("rst_timeout", 64'(timeout), 0);
        check("rst_led", 64'(led), 0);

        // First trigger right after reset release
        rst_n = 1'b1;
        c = cyc;
        wait_rise(cur_r, 5);
        check("first_rise", 64'(cur_r), 64'(c + 1));
        check("busy_trig", 64'(busy), 1);

        // Directed: nominal echo, missing echo, boundaries, averaging sequence
        run(5, 100);
        run(0, 0);
        run(RTO - 3, 50);
        run(10, ETO);
        run(10, ETO + 1);
        run(0, 1);
        run(20, 100);
        run(20, 200);
        run(20, 200);
        run(20, 200);

        // Randomized mix of valid widths, width timeouts and missing echoes
        for (int i = 0; i < 10; i++) begin
            sel = int'($urandom_range(0, 9));
            d   = int'($urandom_range(0, RTO - 3));
            if (sel < 6)      w = int'($urandom_range(1, ETO));
            else if (sel < 9) w = int'($urandom_range(ETO + 1, 200));
            else              w = 0;
            run(d, w);
        end

        // Stuck-high echo stretches the period past PER
        run(10, 450);

        // enable dropped mid-measurement: completes, then idles with no trigger
        wait_fall(f);
        meas(cur_r, f, 5, 100, 1'b0, f + 25, c);
        check("idle_busy", 64'(busy), 0);
        check("idle_trig", 64'(trig), 0);
        r0 = rise_cnt;
        repeat (PER) step();
        check("idle_no_trig", 64'(rise_cnt - r0), 0);

        enable = 1'b1;
        c = cyc;
        wait_rise(cur_r, 5);
        check("reenable_rise", 64'(cur_r), 64'(c + 1));

        // Reset mid-trigger drops trig asynchronously and clears the result
        repeat (3) step();
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_trig", 64'(trig), 0);
        check("async_rst_busy", 64'(busy), 0);
        check("async_rst_echo", 64'(echo_cycles), 0);
        check("async_rst_valid", 64'(valid), 0);
        repeat (3) step();
        hi_len   = 0;
        exp_echo = '0;
        hist.delete();
        rst_n = 1'b1;
        c = cyc;
        wait_rise(cur_r, 5);
        check("post_rst_rise", 64'(cur_r), 64'(c + 1));
        run(7, 80);
        run(3, 120);

        check("valid_timeout_overlap", 64'(both), 0);
        check("strobe_multi_cycle", 64'(dbl), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
